// File: rtl/conv_pass_sequencer.sv
// Layer-level pass scheduler for the conv engine: weight load, clear, run, drain per pass, with output bank ping-pong.
// Optional PERF_CNT_EN adds run/stall performance counters.
module conv_pass_sequencer #(
    parameter int PASS_BITWIDTH = 4,
    parameter int CLR_CYCLES    = 2,
    parameter int DRAIN_CYCLES  = 4,
    parameter int CNT_BITWIDTH  = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     layer_start,
    input  logic                     layer_abort,
    input  logic [PASS_BITWIDTH-1:0] cfg_num_passes,
    input  logic                     wload_ack,
    input  logic                     conv_done,
    output logic                     wload_req,
    output logic                     conv_clear,
    output logic                     conv_enable,
    output logic [PASS_BITWIDTH-1:0] pass_idx,
    output logic                     bank_sel,
    output logic                     busy,
    output logic                     layer_done
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]              perf_run_cycles,
    output logic [31:0]              perf_stall_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_WLOAD, S_CLR, S_RUN, S_DRAIN, S_NEXT, S_FIN
    } state_t;

    localparam logic [CNT_BITWIDTH-1:0] CLR_LOAD   = CNT_BITWIDTH'(CLR_CYCLES - 1);
    localparam logic [CNT_BITWIDTH-1:0] DRAIN_LOAD = CNT_BITWIDTH'(DRAIN_CYCLES - 1);

    state_t                   state;
    logic [CNT_BITWIDTH-1:0]  cnt;
    logic [PASS_BITWIDTH-1:0] num_passes;
    logic                     start_accept;

    assign start_accept = (state == S_IDLE) && layer_start && !layer_abort;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            num_passes <= '0;
            pass_idx   <= '0;
            bank_sel   <= 1'b0;
        end else if (layer_abort && state != S_IDLE) begin
            state    <= S_IDLE;
            cnt      <= '0;
            pass_idx <= '0;
            bank_sel <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_accept) begin
                        if (cfg_num_passes != '0) begin
                            num_passes <= cfg_num_passes;
                            pass_idx   <= '0;
                            bank_sel   <= 1'b0;
                            state      <= S_WLOAD;
                        end else begin
                            state <= S_FIN;
                        end
                    end
                end
                S_WLOAD: begin
                    if (wload_ack) begin
                        cnt   <= CLR_LOAD;
                        state <= S_CLR;
                    end
                end
                S_CLR: begin
                    if (cnt == '0) state <= S_RUN;
                    else           cnt   <= cnt - 1'b1;
                end
                S_RUN: begin
                    if (conv_done) begin
                        cnt   <= DRAIN_LOAD;
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (cnt == '0) state <= S_NEXT;
                    else           cnt   <= cnt - 1'b1;
                end
                S_NEXT: begin
                    // Final pass leaves pass_idx/bank_sel pointing at the last pass
                    if (pass_idx == num_passes - 1'b1) begin
                        state <= S_FIN;
                    end else begin
                        pass_idx <= pass_idx + 1'b1;
                        bank_sel <= ~bank_sel;
                        state    <= S_WLOAD;
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign wload_req   = (state == S_WLOAD);
    assign conv_clear  = (state == S_CLR);
    assign conv_enable = (state == S_RUN);
    assign layer_done  = (state == S_FIN);
    assign busy        = (state != S_IDLE) && (state != S_FIN);

`ifdef PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset || start_accept) begin
            perf_run_cycles   <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (state == S_RUN && perf_run_cycles != '1)
                perf_run_cycles <= perf_run_cycles + 32'd1;
            if (state == S_WLOAD && !wload_ack && perf_stall_cycles != '1)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_pass_sequencer.sv
// Bench for conv_pass_sequencer: expected per-cycle output trace built from pass timing rules, replayed open-loop.
module tb_conv_pass_sequencer;

    localparam int PW  = 4;
    localparam int CLR = 2;
    localparam int DRN = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          layer_start = 1'b0;
    logic          layer_abort = 1'b0;
    logic [PW-1:0] cfg_num_passes = '0;
    logic          wload_ack = 1'b0;
    logic          conv_done = 1'b0;
    logic          wload_req, conv_clear, conv_enable, bank_sel, busy, layer_done;
    logic [PW-1:0] pass_idx;
`ifdef PERF_CNT_EN
    logic [31:0]   perf_run_cycles, perf_stall_cycles;
`endif

    always #5 clock = ~clock;

    conv_pass_sequencer #(
        .PASS_BITWIDTH(PW), .CLR_CYCLES(CLR), .DRAIN_CYCLES(DRN), .CNT_BITWIDTH(8)
    ) dut (
        .clock(clock), .reset(reset), .layer_start(layer_start), .layer_abort(layer_abort),
        .cfg_num_passes(cfg_num_passes), .wload_ack(wload_ack), .conv_done(conv_done),
        .wload_req(wload_req), .conv_clear(conv_clear), .conv_enable(conv_enable),
        .pass_idx(pass_idx), .bank_sel(bank_sel), .busy(busy), .layer_done(layer_done)
`ifdef PERF_CNT_EN
        , .perf_run_cycles(perf_run_cycles), .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    // One entry per clock cycle: inputs held during the cycle and outputs expected during it.
    // ph: 0 idle, 1 weight load, 2 clear, 3 run, 4 drain, 5 next, 6 finish
    typedef struct {
        bit          rst, start, abort, ack, done;
        bit [PW-1:0] cfg;
        int          ph;
        bit          req, clr, en, busy, ldone, bank;
        bit [PW-1:0] idx;
    } cyc_t;

    cyc_t        q[$];
    bit [PW-1:0] m_idx  = '0;
    bit          m_bank = 1'b0;
    int          m_run  = 0;
    int          m_stall = 0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit coin();
        return ($urandom_range(0, 3) == 0);
    endfunction

    function automatic cyc_t base();
        cyc_t c;
        c = '{default: 0};
        c.idx  = m_idx;
        c.bank = m_bank;
        return c;
    endfunction

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) q.push_back(base());
    endtask

    // Builds a full layer; rnd draws per-pass timing and sprinkles inputs that must be ignored.
    task automatic add_layer(input int n, input int ad_i, input int rl_i, input bit rnd);
        cyc_t c;
        int   ad, rl;
        c = base(); c.start = 1; c.cfg = PW'(n);
        q.push_back(c);
        if (n == 0) begin
            c = base(); c.ph = 6; c.ldone = 1;
            q.push_back(c);
            return;
        end
        m_idx = '0; m_bank = 1'b0;
        for (int p = 0; p < n; p++) begin
            ad = rnd ? int'($urandom_range(0, 4)) : ad_i;
            rl = rnd ? int'($urandom_range(1, 10)) : rl_i;
            for (int k = 0; k <= ad; k++) begin
                c = base(); c.ph = 1; c.busy = 1; c.req = 1; c.ack = (k == ad);
                if (rnd && k < ad) begin
                    c.done = coin(); c.start = coin(); c.cfg = PW'($urandom);
                end
                q.push_back(c);
            end
            for (int k = 0; k < CLR; k++) begin
                c = base(); c.ph = 2; c.busy = 1; c.clr = 1;
                if (rnd) begin c.done = coin(); c.ack = coin(); c.start = coin(); end
                q.push_back(c);
            end
            for (int k = 0; k < rl; k++) begin
                c = base(); c.ph = 3; c.busy = 1; c.en = 1; c.done = (k == rl - 1);
                if (rnd) begin c.ack = coin(); c.start = coin(); c.cfg = PW'($urandom); end
                q.push_back(c);
            end
            for (int k = 0; k < DRN; k++) begin
                c = base(); c.ph = 4; c.busy = 1;
                if (rnd) begin c.ack = coin(); c.done = coin(); c.start = coin(); end
                q.push_back(c);
            end
            c = base(); c.ph = 5; c.busy = 1;
            if (rnd) begin c.ack = coin(); c.done = coin(); c.start = coin(); end
            q.push_back(c);
            if (p < n - 1) begin
                m_idx  = m_idx + 1'b1;
                m_bank = ~m_bank;
            end
        end
        c = base(); c.ph = 6; c.ldone = 1;
        if (rnd) begin c.ack = coin(); c.done = coin(); end
        q.push_back(c);
    endtask

    // Layer cut short by abort (kind 0) or reset (kind 1) in the given phase.
    task automatic add_cut(input int n, input int ad, input int rl, input int ph, input bit kind);
        int j;
        j = q.size();
        add_layer(n, ad, rl, 1'b0);
        while (q[j].ph != ph) j++;
        if (q[j + 1].ph == ph) j++;
        if (kind) q[j].rst = 1; else q[j].abort = 1;
        while (q.size() > j + 1) void'(q.pop_back());
        m_idx = '0; m_bank = 1'b0;
        add_idle(2);
    endtask

    task automatic run_queue();
        cyc_t c;
        for (int i = 0; i < q.size(); i++) begin
            c = q[i];
            chk("wload_req",   i, 32'(wload_req),   32'(c.req));
            chk("conv_clear",  i, 32'(conv_clear),  32'(c.clr));
            chk("conv_enable", i, 32'(conv_enable), 32'(c.en));
            chk("pass_idx",    i, 32'(pass_idx),    32'(c.idx));
            chk("bank_sel",    i, 32'(bank_sel),    32'(c.bank));
            chk("busy",        i, 32'(busy),        32'(c.busy));
            chk("layer_done",  i, 32'(layer_done),  32'(c.ldone));
            chk("strobe_excl", i, 32'($countones({wload_req, conv_clear, conv_enable}) <= 1), 32'd1);
`ifdef PERF_CNT_EN
            chk("perf_run",    i, perf_run_cycles,   32'(m_run));
            chk("perf_stall",  i, perf_stall_cycles, 32'(m_stall));
`endif
            reset = c.rst; layer_start = c.start; layer_abort = c.abort;
            wload_ack = c.ack; conv_done = c.done; cfg_num_passes = c.cfg;
            if (c.rst || (c.ph == 0 && c.start && !c.abort)) begin
                m_run = 0; m_stall = 0;
            end else begin
                if (c.en) m_run++;
                if (c.req && !c.ack) m_stall++;
            end
            @(posedge clock); #1;
        end
        q.delete();
        reset = 0; layer_start = 0; layer_abort = 0; wload_ack = 0; conv_done = 0; cfg_num_passes = '0;
    endtask

    initial begin
        cyc_t c;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_outputs", 0, 32'({wload_req, conv_clear, conv_enable, bank_sel, busy, layer_done}), 32'd0);
        chk("rst_pass_idx", 0, 32'(pass_idx), 32'd0);
        reset = 0;
        add_idle(2);
        run_queue();

        add_layer(3, 2, 10, 1'b0); add_idle(3); run_queue();
        add_layer(1, 0, 1, 1'b0);  add_idle(2); run_queue();
        add_layer(0, 0, 0, 1'b0);  add_idle(3); run_queue();

        c = base(); c.start = 1; c.abort = 1; c.cfg = 4'd3;
        q.push_back(c); add_idle(2); run_queue();

        add_cut(3, 1, 5, 3, 1'b0); add_layer(2, 1, 3, 1'b0); add_idle(2);
        add_cut(2, 3, 4, 1, 1'b0); add_layer(2, 0, 2, 1'b0); add_idle(2);
        add_cut(2, 0, 3, 4, 1'b0); add_layer(2, 2, 1, 1'b0); add_idle(2);
        run_queue();

        for (int l = 0; l < 6; l++) begin
            add_layer(int'($urandom_range(1, 4)), 0, 0, 1'b1);
            add_idle(int'($urandom_range(1, 3)));
        end
        run_queue();

        add_layer(2, 3, 20, 1'b0); add_idle(2); run_queue();
`ifdef PERF_CNT_EN
        chk("perf_run_total",   0, perf_run_cycles,   32'd40);
        chk("perf_stall_total", 0, perf_stall_cycles, 32'd6);
`endif
        add_cut(2, 1, 6, 3, 1'b1); add_layer(1, 0, 2, 1'b0); add_idle(2); run_queue();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
